// File: rtl/f1_pkg.sv
// Shared types and helpers for the F1 start-light sequencer.
// Lamp patterns are built at the maximum width and trimmed by the user.
package f1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD,
        ST_TIMING,
        ST_DONE,
        ST_FAULT
    } f1_state_t;

    localparam int F1_CW_DEFAULT = 16;
    localparam int F1_MAX_LIGHTS = 32;
    localparam int F1_IDX_W      = $clog2(F1_MAX_LIGHTS + 1);
    localparam int F1_PAT_W      = F1_MAX_LIGHTS + 1;

    // idx counts lit lamps; idx==0 means dark in both modes.
    function automatic logic [F1_MAX_LIGHTS-1:0] lamp_pattern(
        input logic [F1_IDX_W-1:0] idx,
        input logic                fill_mode
    );
        logic [F1_PAT_W-1:0] one_hot;
        one_hot = F1_PAT_W'(1) << idx;
        if (idx == '0) begin
            return '0;
        end
        if (fill_mode) begin
            return F1_MAX_LIGHTS'(one_hot - F1_PAT_W'(1));
        end
        return one_hot[F1_MAX_LIGHTS:1];
    endfunction

endpackage

// File: rtl/f1_start_seq_react_timer.sv
// Saturating reaction-time counter; clear has priority over increment.
module f1_react_timer
    import f1_pkg::*;
#(
    parameter int CW = F1_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          sat
);

    assign sat = &count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: lamp fill, random hold, reaction timing and
// jump-start detection around a single state register.
module f1_start_seq
    import f1_pkg::*;
#(
    parameter int N_LIGHTS  = 8,
    parameter int CW        = F1_CW_DEFAULT,
    parameter int FILL_MODE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                react,
    input  logic                delay_done,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                cmd_seq,
    output logic                cmd_delay,
    output logic                busy,
    output logic [CW-1:0]       react_time,
    output logic                react_valid,
    output logic                jump_start
);

    localparam int              IW   = $clog2(N_LIGHTS + 1);
    localparam logic [IW-1:0]   LAST = IW'(N_LIGHTS);

    f1_state_t                  state;
    logic [IW-1:0]              idx;
    logic                       trig_pend;
    logic                       trig_now;
    logic [CW-1:0]              count;
    logic                       count_sat;
    logic                       timer_clr;
    logic                       timer_inc;
    logic [F1_MAX_LIGHTS-1:0]   pattern;

    // A trigger arriving in the same cycle as the starting tick counts.
    assign trig_now  = trig_pend || trigger;
    assign timer_clr = (state == ST_HOLD) && delay_done && !react;
    assign timer_inc = (state == ST_TIMING) && en && !count_sat;

    f1_react_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .inc   (timer_inc),
        .count (count),
        .sat   (count_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            trig_pend   <= 1'b0;
            cmd_delay   <= 1'b0;
            react_time  <= '0;
            react_valid <= 1'b0;
            jump_start  <= 1'b0;
        end else begin
            cmd_delay   <= 1'b0;
            react_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    if (en && trig_now) begin
                        state      <= ST_FILL;
                        idx        <= IW'(1);
                        trig_pend  <= 1'b0;
                        jump_start <= 1'b0;
                    end else if (trigger) begin
                        trig_pend <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (react) begin
                        state      <= ST_FAULT;
                        jump_start <= 1'b1;
                    end else if (en) begin
                        if (idx == LAST) begin
                            state     <= ST_HOLD;
                            cmd_delay <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // An early button press beats a simultaneous hold expiry.
                    if (react) begin
                        state      <= ST_FAULT;
                        jump_start <= 1'b1;
                    end else if (delay_done) begin
                        state <= ST_TIMING;
                    end
                end
                ST_TIMING: begin
                    if (react) begin
                        state       <= ST_DONE;
                        react_time  <= count;
                        react_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lamps show only while filling or holding; idx stays at the top in HOLD.
    always_comb begin
        pattern  = lamp_pattern(F1_IDX_W'(idx), FILL_MODE != 0);
        data_out = '0;
        if (state == ST_FILL || state == ST_HOLD) begin
            data_out = pattern[N_LIGHTS-1:0];
        end
    end

    assign busy    = (state == ST_FILL) || (state == ST_HOLD) || (state == ST_TIMING);
    assign cmd_seq = !((state == ST_HOLD) || (state == ST_TIMING));

endmodule

// File: tb/tb_f1_start_seq.sv
// Randomised and directed bench for f1_start_seq: two instances (cumulative, CW=8
// and walking, CW=4) share stimulus and are checked against one behavioural model.
module tb_f1_start_seq;

    localparam int P_IDLE   = 0;
    localparam int P_FILL   = 1;
    localparam int P_HOLD   = 2;
    localparam int P_TIMING = 3;
    localparam int P_DONE   = 4;
    localparam int P_FAULT  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, trigger = 1'b0, react = 1'b0, delay_done = 1'b0;

    logic [3:0] a_data, b_data;
    logic       a_seq, a_dly, a_busy, a_rv, a_js;
    logic       b_seq, b_dly, b_busy, b_rv, b_js;
    logic [7:0] a_rt;
    logic [3:0] b_rt;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: phase, lamps lit, unbounded tick count, latched result.
    int m_phase = P_IDLE;
    int m_lit   = 0;
    int m_ticks = 0;
    int m_rt    = 0;
    bit m_pend  = 0;
    bit m_valid = 0;
    bit m_delay = 0;
    bit m_js    = 0;

    always #5 clk = ~clk;

    f1_start_seq #(.N_LIGHTS(4), .CW(8), .FILL_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .react(react),
        .delay_done(delay_done), .data_out(a_data), .cmd_seq(a_seq),
        .cmd_delay(a_dly), .busy(a_busy), .react_time(a_rt),
        .react_valid(a_rv), .jump_start(a_js)
    );

    f1_start_seq #(.N_LIGHTS(4), .CW(4), .FILL_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .react(react),
        .delay_done(delay_done), .data_out(b_data), .cmd_seq(b_seq),
        .cmd_delay(b_dly), .busy(b_busy), .react_time(b_rt),
        .react_valid(b_rv), .jump_start(b_js)
    );

    task automatic model_update(input bit r, input bit trg, input bit e, input bit rc, input bit dd);
        bit pending;
        m_valid = 0;
        m_delay = 0;
        if (r) begin
            m_phase = P_IDLE; m_lit = 0; m_ticks = 0; m_rt = 0;
            m_pend = 0; m_js = 0;
            return;
        end
        if (m_phase == P_IDLE || m_phase == P_DONE || m_phase == P_FAULT) begin
            pending = m_pend || trg;
            if (e && pending) begin
                m_phase = P_FILL; m_lit = 1; m_pend = 0; m_js = 0;
            end else begin
                m_pend = pending;
            end
        end else if (m_phase == P_FILL) begin
            if (rc) begin
                m_phase = P_FAULT; m_js = 1;
            end else if (e) begin
                if (m_lit == 4) begin
                    m_phase = P_HOLD; m_delay = 1;
                end else begin
                    m_lit++;
                end
            end
        end else if (m_phase == P_HOLD) begin
            if (rc) begin
                m_phase = P_FAULT; m_js = 1;
            end else if (dd) begin
                m_phase = P_TIMING; m_ticks = 0;
            end
        end else begin
            if (rc) begin
                m_phase = P_DONE; m_rt = m_ticks; m_valid = 1;
            end else if (e) begin
                m_ticks++;
            end
        end
    endtask

    task automatic step(input bit trg, input bit e, input bit rc, input bit dd);
        trigger = trg; en = e; react = rc; delay_done = dd;
        @(posedge clk);
        model_update(rst, trg, e, rc, dd);
        #1;
    endtask

    // cmd_seq is only defined for IDLE/FILL/HOLD/TIMING, so it is masked elsewhere.
    function automatic bit seq_masked();
        return (m_phase == P_DONE) || (m_phase == P_FAULT);
    endfunction

    function automatic logic [29:0] obs_vec();
        logic sa, sb;
        sa = seq_masked() ? 1'b0 : a_seq;
        sb = seq_masked() ? 1'b0 : b_seq;
        return {a_data, b_data, sa, a_dly, a_busy, a_rt, a_rv, a_js,
                b_rt, sb, b_dly, b_busy, b_rv, b_js};
    endfunction

    function automatic logic [29:0] exp_vec();
        logic [3:0] ea, eb, rtb;
        logic [7:0] rta;
        logic       seq, bsy, dly, vld, js;
        ea = 4'h0;
        eb = 4'h0;
        if (m_phase == P_FILL) begin
            ea = 4'((2 ** m_lit) - 1);
            eb = 4'(2 ** (m_lit - 1));
        end else if (m_phase == P_HOLD) begin
            ea = 4'hF;
            eb = 4'h8;
        end
        rta = (m_rt > 255) ? 8'd255 : 8'(m_rt);
        rtb = (m_rt > 15) ? 4'd15 : 4'(m_rt);
        bsy = (m_phase == P_FILL) || (m_phase == P_HOLD) || (m_phase == P_TIMING);
        seq = seq_masked() ? 1'b0 : ((m_phase == P_IDLE) || (m_phase == P_FILL));
        dly = m_delay;
        vld = m_valid;
        js  = m_js;
        return {ea, eb, seq, dly, bsy, rta, vld, js, rtb, seq, dly, bsy, vld, js};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_state observed=%h required=%h", obs_vec(), exp_vec());
        end
        vectors++;
        if ({a_data, a_seq, a_dly, a_busy, a_rt, a_rv, a_js} !== {4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_values observed=%h required=%h",
                     {a_data, a_seq, a_dly, a_busy, a_rt, a_rv, a_js}, {4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_sequence();
        step(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, (i != 2), 0, 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL fill[%0d] observed=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        step(0, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        vectors++;
        if ({a_rt, a_rv, a_data, b_rt} !== {8'd5, 1'b1, 4'h0, 4'd5}) begin
            miscompares++;
            $display("[TB] FAIL react_time_5 observed=%h required=%h", {a_rt, a_rv, a_data, b_rt}, {8'd5, 1'b1, 4'h0, 4'd5});
        end
        step(0, 1, 0, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL valid_single observed=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_jump_start();
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        vectors++;
        if ({a_js, b_js, a_rt, a_data, a_busy} !== {1'b1, 1'b1, 8'd5, 4'h0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL jump_start observed=%h required=%h", {a_js, b_js, a_rt, a_data, a_busy}, {1'b1, 1'b1, 8'd5, 4'h0, 1'b0});
        end
        step(0, 1, 1, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL fault_restart observed=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_react_with_delay_done();
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        vectors++;
        if ({a_js, a_busy, a_data} !== {1'b1, 1'b0, 4'h0} || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL react_beats_delay observed=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_saturation();
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        vectors++;
        if ({a_rt, b_rt} !== {8'd20, 4'd15}) begin
            miscompares++;
            $display("[TB] FAIL saturate observed=%h required=%h", {a_rt, b_rt}, {8'd20, 4'd15});
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL no_restart[%0d] observed=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_in_hold();
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        vectors++;
        if ({a_data, a_seq, a_dly, a_busy, a_rt, a_rv, a_js} !== {4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_hold observed=%h required=%h",
                     {a_data, a_seq, a_dly, a_busy, a_rt, a_rv, a_js}, {4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
        end
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1);
            vectors++;
            if (a_busy !== 1'b0 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL pend_discard[%0d] observed=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0);
            rst = 1'b0;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] observed=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_jump_start();
        test_react_with_delay_done();
        test_saturation();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
